// File: rtl/mdu_iter.sv
// Multiply/divide unit owning HI/LO: multiplies complete after MUL_LAT busy cycles,
// divides after WIDTH restoring steps plus a sign-fix cycle; req cancels in-flight work.
module mdu_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [3:0]       op,
    input  logic             req,
    output logic             start_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] out
);

    localparam int CW = $clog2(WIDTH + 16);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_pend;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvsr;
    logic               r_qneg;
    logic               r_rneg;
    logic               r_div0;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_signed;
    logic               w_acc;
    logic               w_sub;
    logic               w_accept;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_hilo;
    logic [2*WIDTH-1:0] w_mul_res;
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;
    logic               w_div0;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_mul_done;
    logic               w_div_done;

    always_comb begin
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        w_signed = 1'b0;
        w_acc    = 1'b0;
        w_sub    = 1'b0;
        case (op)
            4'd1:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
            4'd2:  w_is_mul = 1'b1;
            4'd3:  begin w_is_div = 1'b1; w_signed = 1'b1; end
            4'd4:  w_is_div = 1'b1;
            4'd9:  begin w_is_mul = 1'b1; w_signed = 1'b1; w_acc = 1'b1; end
            4'd10: begin w_is_mul = 1'b1; w_acc = 1'b1; end
            4'd11: begin w_is_mul = 1'b1; w_signed = 1'b1; w_acc = 1'b1; w_sub = 1'b1; end
            4'd12: begin w_is_mul = 1'b1; w_acc = 1'b1; w_sub = 1'b1; end
            default: ;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && !req;
    assign start_o  = w_accept && (w_is_mul || w_is_div);
    assign busy_o   = (r_state != S_IDLE);

    // Sign-extending to 2*WIDTH lets one truncated multiply serve both signednesses.
    assign w_a_ext   = w_signed ? {{WIDTH{rs[WIDTH-1]}}, rs} : {{WIDTH{1'b0}}, rs};
    assign w_b_ext   = w_signed ? {{WIDTH{rt[WIDTH-1]}}, rt} : {{WIDTH{1'b0}}, rt};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_hilo    = {r_hi, r_lo};
    assign w_mul_res = !w_acc ? w_prod : (w_sub ? w_hilo - w_prod : w_hilo + w_prod);

    assign w_rs_neg = w_signed && rs[WIDTH-1];
    assign w_rt_neg = w_signed && rt[WIDTH-1];
    assign w_rs_mag = w_rs_neg ? -rs : rs;
    assign w_rt_mag = w_rt_neg ? -rt : rt;
    assign w_div0   = (rt == '0);

    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvsr};

    assign w_mul_done = (r_state == S_MUL) && !req && (r_cnt == CW'(1));
    assign w_div_done = (r_state == S_DIV) && !req && (r_cnt == '0) && !r_div0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start_o) w_next = w_is_mul ? S_MUL : S_DIV;
            S_MUL:  if (req || r_cnt == CW'(1)) w_next = S_IDLE;
            S_DIV:  if (req || r_cnt == '0) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_cnt  <= '0;
            r_pend <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvsr <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_div0 <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && op == 4'd7) r_hi <= rs;
                    if (w_accept && op == 4'd8) r_lo <= rs;
                    if (start_o && w_is_mul) begin
                        r_pend <= w_mul_res;
                        r_cnt  <= CW'(MUL_LAT);
                    end
                    if (start_o && w_is_div) begin
                        r_cnt  <= w_div0 ? '0 : CW'(WIDTH);
                        r_rem  <= '0;
                        r_quo  <= w_rs_mag;
                        r_dvsr <= w_rt_mag;
                        r_qneg <= w_rs_neg ^ w_rt_neg;
                        r_rneg <= w_rs_neg;
                        r_div0 <= w_div0;
                    end
                end
                S_MUL: begin
                    if (w_mul_done)  {r_hi, r_lo} <= r_pend;
                    else if (!req)   r_cnt <= r_cnt - CW'(1);
                end
                S_DIV: begin
                    // Restoring step: one quotient bit per cycle, remainder kept below the divisor.
                    if (!req && r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                        if (!w_diff[WIDTH]) begin
                            r_rem <= w_diff[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                        end
                    end
                    if (w_div_done) begin
                        r_lo <= r_qneg ? -r_quo : r_quo;
                        r_hi <= r_rneg ? -r_rem : r_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out = '0;
        if (op == 4'd5)      out = r_hi;
        else if (op == 4'd6) out = r_lo;
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboarded bench for mdu_iter: stimulus updates a behavioural HI/LO model and queues
// expected reads, accept strobes and busy lengths; a negedge monitor compares them.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rs, rt, out;
    logic [3:0]  op;
    logic        req, start_o, busy_o;

    logic [15:0] rs16, rt16, out16;
    logic [3:0]  op16;
    logic        req16, start16, busy16;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(32), .MUL_LAT(5)) u_dut (
        .clk(clk), .reset(reset), .rs(rs), .rt(rt), .op(op), .req(req),
        .start_o(start_o), .busy_o(busy_o), .out(out)
    );

    mdu_iter #(.WIDTH(16), .MUL_LAT(1)) u_dut16 (
        .clk(clk), .reset(reset), .rs(rs16), .rt(rt16), .op(op16), .req(req16),
        .start_o(start16), .busy_o(busy16), .out(out16)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] val;
    } rd_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi, m_lo;
    rd_t         q_rd[$];
    int          q_busy[$];
    logic        q_start[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT event with no expected entry queued", name);
    endtask

    // Monitor
    initial begin
        int   run;
        rd_t  e;
        int   eb;
        logic es;
        run = 0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && (op == 4'd5 || op == 4'd6) && busy_o === 1'b0) begin
                if (q_rd.size() == 0) unexpected("read");
                else begin
                    e = q_rd.pop_front();
                    chk("rd_op", op, e.op);
                    chk((op == 4'd5) ? "mfhi" : "mflo", out, e.val);
                end
            end
            if (reset === 1'b1 && op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8,
                                             4'd9, 4'd10, 4'd11, 4'd12}) begin
                if (q_start.size() == 0) unexpected("start");
                else begin
                    es = q_start.pop_front();
                    chk("start_o", start_o, es);
                end
            end
            if (busy_o === 1'b1) run++;
            else if (run > 0) begin
                if (q_busy.size() == 0) unexpected("busy_len");
                else begin
                    eb = q_busy.pop_front();
                    chk("busy_len", run, eb);
                end
                run = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic rq);
        op = o; rs = a; rt = b; req = rq;
        @(posedge clk); #1;
        op = 4'd0; req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o !== 1'b0 && n < 100) begin
            cyc(4'd0, 32'd0, 32'd0, 1'b0);
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: busy_o still %b after %0d cycles, expected 0", busy_o, n);
        end
    endtask

    task automatic rd();
        q_rd.push_back('{op: 4'd5, val: m_hi});
        cyc(4'd5, 32'd0, 32'd0, 1'b0);
        q_rd.push_back('{op: 4'd6, val: m_lo});
        cyc(4'd6, 32'd0, 32'd0, 1'b0);
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural HI/LO pair.
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p, hl;
        longint      sa, sb, q, r;
        hl = {m_hi, m_lo};
        case (o)
            4'd1, 4'd2, 4'd9, 4'd10, 4'd11, 4'd12: begin
                if (o == 4'd1 || o == 4'd9 || o == 4'd11)
                    p = longint'($signed(a)) * longint'($signed(b));
                else
                    p = {32'd0, a} * {32'd0, b};
                if (o == 4'd9 || o == 4'd10)      hl = hl + p;
                else if (o == 4'd11 || o == 4'd12) hl = hl - p;
                else                               hl = p;
                q_start.push_back(1'b1);
                q_busy.push_back(5);
            end
            4'd3, 4'd4: begin
                q_start.push_back(1'b1);
                if (b == 32'd0) q_busy.push_back(1);
                else begin
                    if (o == 4'd3) begin
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                    end else begin
                        sa = longint'({32'd0, a});
                        sb = longint'({32'd0, b});
                    end
                    q = sa / sb;
                    r = sa % sb;
                    hl = {r[31:0], q[31:0]};
                    q_busy.push_back(33);
                end
            end
            4'd7: begin hl[63:32] = a; q_start.push_back(1'b0); end
            4'd8: begin hl[31:0]  = a; q_start.push_back(1'b0); end
            default: ;
        endcase
        {m_hi, m_lo} = hl;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        model(o, a, b);
        cyc(o, a, b, 1'b0);
        wait_idle();
    endtask

    logic [3:0] ops [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};

    initial begin
        logic [31:0] a, b;
        logic [3:0]  o;
        longint      p16;
        reset = 1'b0; op = 4'd0; rs = '0; rt = '0; req = 1'b0;
        op16 = 4'd0; rs16 = '0; rt16 = '0; req16 = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_start", start_o, 1'b0);
        reset = 1'b1;
        rd();

        // Signed multiply, held into the busy period: second presentation is ignored.
        model(4'd1, 32'hFFFF_FFFE, 32'd3);
        q_start.push_back(1'b0);
        cyc(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        cyc(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_idle();
        rd();

        issue(4'd3, 32'hFFFF_FFF9, 32'd2);  rd();
        issue(4'd4, 32'hFFFF_FFFF, 32'h10); rd();
        issue(4'd3, 32'd1234, 32'd0);       rd();

        issue(4'd7, 32'd0, 32'd0);
        issue(4'd8, 32'hFFFF_FFFF, 32'd0);
        issue(4'd10, 32'd1, 32'd1); rd();
        issue(4'd11, 32'd2, 32'd3); rd();

        // Cancel a divide at busy cycle 10.
        q_start.push_back(1'b1);
        q_busy.push_back(10);
        cyc(4'd3, 32'd100, 32'd7, 1'b0);
        repeat (9) cyc(4'd0, 32'd0, 32'd0, 1'b0);
        cyc(4'd0, 32'd0, 32'd0, 1'b1);
        chk("cancel_busy", busy_o, 1'b0);
        rd();

        // Cancel in the final multiply busy cycle: no commit.
        q_start.push_back(1'b1);
        q_busy.push_back(5);
        cyc(4'd1, 32'd1000, 32'd1000, 1'b0);
        repeat (4) cyc(4'd0, 32'd0, 32'd0, 1'b0);
        cyc(4'd0, 32'd0, 32'd0, 1'b1);
        rd();

        q_start.push_back(1'b0);
        cyc(4'd8, 32'd55, 32'd0, 1'b1);
        rd();
        cyc(4'd0, 32'd0, 32'd0, 1'b1);
        rd();

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF); rd();

        for (int i = 0; i < 40; i++) begin
            o = ops[$urandom_range(0, 9)];
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = -$urandom_range(1, 15);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
            issue(o, a, b);
            rd();
        end

        // Asynchronous reset during busy cycle 3 of a multiply.
        issue(4'd7, 32'hA5A5_A5A5, 32'd0);
        issue(4'd8, 32'h5A5A_5A5A, 32'd0);
        q_start.push_back(1'b1);
        q_busy.push_back(2);
        cyc(4'd1, 32'd7, 32'd9, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        op = 4'd5;
        #1;
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_hi", out, 32'd0);
        op = 4'd6;
        #1;
        chk("arst_lo", out, 32'd0);
        op = 4'd0;
        @(posedge clk); #1;
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        rd();

        // WIDTH=16, MUL_LAT=1 instance.
        p16 = longint'($signed(16'hFFFE)) * longint'(3);
        op16 = 4'd1; rs16 = 16'hFFFE; rt16 = 16'd3;
        #1;
        chk("w16_start", start16, 1'b1);
        @(posedge clk); #1;
        op16 = 4'd0;
        #1;
        chk("w16_busy1", busy16, 1'b1);
        @(posedge clk); #1;
        chk("w16_busy_done", busy16, 1'b0);
        op16 = 4'd5;
        #1;
        chk("w16_hi", out16, p16[31:16]);
        op16 = 4'd6;
        #1;
        chk("w16_lo", out16, p16[15:0]);
        op16 = 4'd0;

        repeat (3) cyc(4'd0, 32'd0, 32'd0, 1'b0);
        chk("q_rd_left", q_rd.size(), 0);
        chk("q_busy_left", q_busy.size(), 0);
        chk("q_start_left", q_start.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised multiply/divide unit for the E stage of the pipelined MIPS core. It generalises the fixed-latency MDU in three ways: operand width and multiply latency are parameters, division is a true iterative radix-2 divider, and madd/maddu/msub/msubu accumulate into HI/LO. It owns HI/LO, raises `busy_o`/`start_o` for the stall unit, and honours the CP0 exception request `req` by cancelling in-flight work.

## Interface
- `WIDTH`, 32: operand width in bits; HI and LO are each `WIDTH` bits.
- `MUL_LAT`, 5: busy cycles for every multiply-class op; range 1..15.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `rs` in `WIDTH`: operand A, forwarded value.
- `rt` in `WIDTH`: operand B, forwarded value.
- `op` in 4: operation code.
  - 0 none; 1 mult; 2 multu; 3 div; 4 divu; 5 mfhi; 6 mflo; 7 mthi; 8 mtlo.
  - 9 madd; 10 maddu; 11 msub; 12 msubu; 13–15 treated as none.
- `req` in 1: exception/interrupt request from CP0.
- `start_o` out 1: a multiply/divide-class op is accepted this cycle (combinational).
- `busy_o` out 1: an operation is in flight (registered).
- `out` out `WIDTH`: HI when `op`=5, LO when `op`=6, else 0 (combinational).

## Operation
- States: IDLE, MUL, DIV. Reset enters IDLE with HI=LO=0, `busy_o`=0 and the counter at 0.
- Acceptance. An op is accepted in IDLE only when `req`=0.
  - While busy or while `req`=1, every op is ignored and no register is written. The stall unit guarantees a held op re-presents itself later.
- mthi/mtlo write `rs` into HI/LO at the accept edge. They take no busy cycles.
- mfhi/mflo are combinational reads. During busy they return the old HI/LO; the stall unit prevents such a read from being consumed.
- Multiply class (1,2,9–12).
  - Signedness comes from the op.
  - The 2·`WIDTH` product, summed with or subtracted from {HI,LO} for madd/msub, is computed from the accept-cycle operands and held in a pending register.
  - Go to MUL with the counter set to `MUL_LAT`.
  - Accumulation wraps modulo 2^(2·`WIDTH`).
- Divide class (3,4).
  - Signed div takes magnitudes and records the sign of each result: quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
  - Go to DIV for `WIDTH` restoring iterations, one quotient bit per cycle, then one sign-fix cycle.
  - LO = quotient and HI = remainder, truncating toward zero.
  - Overflow case (signed, rs = −2^(`WIDTH`−1), rt = −1): LO = rs, HI = 0.
- Divide by zero: rt = 0 → HI/LO unchanged. The unit still goes busy for exactly 1 cycle, then returns to IDLE.
- MUL/DIV → IDLE when the counter reaches its end. HI/LO are committed on that same edge.
- Cancel. `req`=1 while busy aborts the op on the next edge:
  - HI/LO keep their pre-op values;
  - state becomes IDLE;
  - `busy_o`=0 in the following cycle.
- Reset mid-operation: immediate IDLE, HI=LO=0.

## Timing
- `start_o` = (state==IDLE) & !`req` & op in {1,2,3,4,9–12}.
- Multiply accepted at edge of cycle T:
  - `busy_o`=1 in cycles T+1..T+`MUL_LAT`;
  - HI/LO updated at the end of cycle T+`MUL_LAT`;
  - `busy_o`=0 and new values readable in T+`MUL_LAT`+1.
- Divide (rt≠0) accepted in cycle T:
  - `busy_o`=1 for `WIDTH`+1 cycles, T+1..T+`WIDTH`+1;
  - result readable in T+`WIDTH`+2.
- Back-to-back: a new op may be accepted in the first cycle `busy_o`=0.
- `req` and accept in the same cycle: no accept, and mthi/mtlo do not write.
- `req` in the final busy cycle still cancels, so no commit occurs.
- `req` once already IDLE has no effect on HI/LO.

## Test plan
- Signed multiply: reset, then mult rs=0xFFFFFFFE, rt=3 → `start_o`=1 for 1 cycle, `busy_o`=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; mfhi/mflo return them.
- Signed div with negative remainder: div rs=−7 (0xFFFFFFF9), rt=2 → busy 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Unsigned div and divide by zero:
  - divu 0xFFFFFFFF / 0x10 → LO=0x0FFFFFFF, HI=0xF.
  - Then div by 0 → busy 1 cycle, HI/LO unchanged.
- Accumulate: mthi 0, mtlo 0xFFFFFFFF, then maddu 1×1 → HI=1, LO=0; msub 2×3 → HI=0, LO=0xFFFFFFFA.
- Cancel:
  - Start div, assert `req` at busy cycle 10 → `busy_o`=0 next cycle, HI/LO equal the pre-op values.
  - `req` coincident with mtlo → LO unchanged, `start_o`=0.
- Corners:
  - Signed overflow: div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - Asynchronous reset asserted mid-multiply → `busy_o`=0 and HI=LO=0 immediately, before the next edge.
  - Repeat the multiply test with `WIDTH`=16 and `MUL_LAT`=1 → busy exactly 1 cycle.
